// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: opcode/funct encodings, divider FSM states
// and divide-by-zero results shared by the EX stage.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_MEM_LO = 6'h20;
  localparam logic [5:0] OP_MEM_HI = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Divide by zero: LO gets all ones, HI gets the dividend.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX operands+control in, EX/MEM out.
// slave = EX stage, master = pipeline/bench side.
interface execute_stage_if #(
  parameter int NB           = 32,
  parameter int NB_OPCODE    = 6,
  parameter int NB_FCODE     = 6,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_REGS      = 5
);
  logic [NB_OPCODE-1:0]    i_instruction_op_code;
  logic [NB_FCODE-1:0]     i_instruction_funct_code;
  logic                    i_alu_src;
  logic [NB-1:0]           i_data_a;
  logic [NB-1:0]           i_data_b;
  logic [NB-1:0]           i_extension_result;
  logic [NB-1:0]           i_pc4;
  logic                    i_branch;
  logic                    i_mem_read;
  logic                    i_mem_write;
  logic                    i_reg_write;
  logic [NB_SIZE_TYPE-1:0] i_word_size;
  logic [NB_REGS-1:0]      i_reg_dir_to_write;

  logic [NB-1:0]           o_alu_result;
  logic [NB-1:0]           o_data_b;
  logic [NB-1:0]           o_branch_target;
  logic                    o_branch_taken;
  logic                    o_mem_read;
  logic                    o_mem_write;
  logic                    o_reg_write;
  logic [NB_SIZE_TYPE-1:0] o_word_size;
  logic [NB_REGS-1:0]      o_reg_dir_to_write;

  modport slave (
    input  i_instruction_op_code, i_instruction_funct_code,
    input  i_alu_src, i_data_a, i_data_b,
    input  i_extension_result, i_pc4,
    input  i_branch, i_mem_read, i_mem_write, i_reg_write,
    input  i_word_size, i_reg_dir_to_write,
    output o_alu_result, o_data_b, o_branch_target,
    output o_branch_taken, o_mem_read, o_mem_write,
    output o_reg_write, o_word_size, o_reg_dir_to_write
  );

  modport master (
    output i_instruction_op_code, i_instruction_funct_code,
    output i_alu_src, i_data_a, i_data_b,
    output i_extension_result, i_pc4,
    output i_branch, i_mem_read, i_mem_write, i_reg_write,
    output i_word_size, i_reg_dir_to_write,
    input  o_alu_result, o_data_b, o_branch_target,
    input  o_branch_taken, o_mem_read, o_mem_write,
    input  o_reg_write, o_word_size, o_reg_dir_to_write
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-iteration restoring divider, IDLE/BUSY/DONE.
// start/is_signed/a/b in; busy, done, quotient, remainder out.
module div_unit
  import mips_isa_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          start,
  input  logic          is_signed,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [NB-1:0] quotient,
  output logic [NB-1:0] remainder
);
  localparam int NB_CNT = $clog2(NB);

  div_state_t state, state_nxt;

  logic [NB_CNT-1:0] count;
  logic [NB-1:0]     rem, quo, dvs, a_keep;
  logic [NB-1:0]     a_mag, b_mag;
  logic [NB-1:0]     rem_nxt, quo_nxt;
  logic [NB:0]       r_shift, diff;
  logic              neg_q, neg_r, by_zero;
  logic              last;

  always_ff @(negedge clk) begin
    if (reset) state <= DIV_IDLE;
    else if (step) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start) state_nxt = DIV_BUSY;
      DIV_BUSY: if (last) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  assign last  = busy && (count == NB_CNT'(NB - 1));
  assign a_mag = (is_signed && a[NB-1]) ? -a : a;
  assign b_mag = (is_signed && b[NB-1]) ? -b : b;

  // Shift in next dividend bit; keep the difference if it
  // did not borrow.
  always_comb begin
    r_shift = {rem, quo[NB-1]};
    diff    = r_shift - {1'b0, dvs};
    if (diff[NB]) begin
      rem_nxt = r_shift[NB-1:0];
      quo_nxt = {quo[NB-2:0], 1'b0};
    end else begin
      rem_nxt = diff[NB-1:0];
      quo_nxt = {quo[NB-2:0], 1'b1};
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      a_keep    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      by_zero   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (step) begin
      if (state == DIV_IDLE && start) begin
        count   <= '0;
        rem     <= '0;
        quo     <= a_mag;
        dvs     <= b_mag;
        a_keep  <= a;
        neg_q   <= is_signed & (a[NB-1] ^ b[NB-1]);
        neg_r   <= is_signed & a[NB-1];
        by_zero <= (b == '0);
      end else if (busy) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        count <= count + 1'b1;
        if (last) begin
          quotient  <= by_zero ? DIV0_QUOTIENT :
                       neg_q ? -quo_nxt : quo_nxt;
          remainder <= by_zero ? a_keep :
                       neg_r ? -rem_nxt : rem_nxt;
        end
      end
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage - ALU, branch, HI/LO, MULT/DIV.
// Ports: i_clk/i_reset/i_step, o_stall, ex (ID/EX in, EX/MEM out).
module execute_stage
  import mips_isa_pkg::*;
#(
  parameter int NB           = 32,
  parameter int NB_OPCODE    = 6,
  parameter int NB_FCODE     = 6,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_REGS      = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_step,
  output logic           o_stall,
  execute_stage_if.slave ex
);
  typedef struct packed {
    logic [NB-1:0]           alu_result;
    logic [NB-1:0]           data_b;
    logic [NB-1:0]           branch_target;
    logic                    branch_taken;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic [NB_SIZE_TYPE-1:0] word_size;
    logic [NB_REGS-1:0]      reg_dir;
  } ex_mem_t;

  ex_mem_t ex_mem_d, ex_mem_q;

  logic [NB_OPCODE-1:0] op;
  logic [NB_FCODE-1:0]  fn;
  logic [NB-1:0]        a, b, ext, pc4, op_b, imm_zx;
  logic [NB-1:0]        r_res, i_res, alu_res;
  logic [NB-1:0]        hi, lo, div_quo, div_rem;
  logic [2*NB-1:0]      mul_a, mul_b, prod;
  logic [4:0]           shamt;
  logic                 is_r, is_mem, is_mult, is_div;
  logic                 mul_sgn, taken;
  logic                 div_busy, div_done;

  assign op     = ex.i_instruction_op_code;
  assign fn     = ex.i_instruction_funct_code;
  assign a      = ex.i_data_a;
  assign b      = ex.i_data_b;
  assign ext    = ex.i_extension_result;
  assign pc4    = ex.i_pc4;
  assign op_b   = ex.i_alu_src ? ext : b;
  assign imm_zx = {{(NB-16){1'b0}}, ext[15:0]};
  assign shamt  = ext[10:6];

  assign is_r    = (op == OP_RTYPE);
  assign is_mem  = (op >= OP_MEM_LO) && (op <= OP_MEM_HI);
  assign is_mult = is_r && (fn == FN_MULT || fn == FN_MULTU);
  assign is_div  = is_r && (fn == FN_DIV || fn == FN_DIVU);

  div_unit #(.NB(NB)) u_div (
    .clk       (i_clk),
    .reset     (i_reset),
    .step      (i_step),
    .start     (is_div),
    .is_signed (fn == FN_DIV),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // DIV holds ID/EX until its DONE edge lets it retire.
  assign o_stall = div_busy | (is_div & ~div_done);

  // Low 64 bits of the sign/zero-extended product.
  assign mul_sgn = (fn == FN_MULT);
  assign mul_a   = {{NB{mul_sgn & a[NB-1]}}, a};
  assign mul_b   = {{NB{mul_sgn & b[NB-1]}}, b};
  assign prod    = mul_a * mul_b;

  always_comb begin
    r_res = '0;
    case (fn)
      FN_ADDU: r_res = a + op_b;
      FN_SUBU: r_res = a - op_b;
      FN_AND:  r_res = a & op_b;
      FN_OR:   r_res = a | op_b;
      FN_XOR:  r_res = a ^ op_b;
      FN_NOR:  r_res = ~(a | op_b);
      FN_SLT:  r_res = {{(NB-1){1'b0}},
                        $signed(a) < $signed(op_b)};
      FN_SLTU: r_res = {{(NB-1){1'b0}}, a < op_b};
      FN_SLL:  r_res = op_b << shamt;
      FN_SRL:  r_res = op_b >> shamt;
      FN_SRA:  r_res = $signed(op_b) >>> shamt;
      FN_SLLV: r_res = op_b << a[4:0];
      FN_SRLV: r_res = op_b >> a[4:0];
      FN_SRAV: r_res = $signed(op_b) >>> a[4:0];
      FN_MFHI: r_res = hi;
      FN_MFLO: r_res = lo;
      FN_JALR: r_res = pc4;
      default: r_res = '0;
    endcase
  end

  always_comb begin
    i_res = '0;
    case (op)
      OP_ADDI, OP_ADDIU: i_res = a + ext;
      OP_SLTI:  i_res = {{(NB-1){1'b0}},
                         $signed(a) < $signed(ext)};
      OP_SLTIU: i_res = {{(NB-1){1'b0}}, a < ext};
      OP_ANDI:  i_res = a & imm_zx;
      OP_ORI:   i_res = a | imm_zx;
      OP_XORI:  i_res = a ^ imm_zx;
      OP_LUI:   i_res = {ext[15:0], {(NB-16){1'b0}}};
      OP_JAL:   i_res = pc4;
      default:  i_res = '0;
    endcase
  end

  always_comb begin
    alu_res = i_res;
    unique case (1'b1)
      is_r:    alu_res = r_res;
      is_mem:  alu_res = a + ext;
      default: alu_res = i_res;
    endcase
  end

  assign taken = ex.i_branch &&
                 ((op == OP_BEQ && a == b) ||
                  (op == OP_BNE && a != b));

  always_comb begin
    ex_mem_d.alu_result    = alu_res;
    ex_mem_d.data_b        = b;
    ex_mem_d.branch_target = pc4 + (ext << 2);
    ex_mem_d.branch_taken  = taken;
    ex_mem_d.mem_read      = ex.i_mem_read;
    ex_mem_d.mem_write     = ex.i_mem_write;
    ex_mem_d.reg_write     = ex.i_reg_write;
    ex_mem_d.word_size     = ex.i_word_size;
    ex_mem_d.reg_dir       = ex.i_reg_dir_to_write;
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      hi <= '0;
      lo <= '0;
    end else if (i_step) begin
      if (div_done) begin
        hi <= div_rem;
        lo <= div_quo;
      end else if (is_mult) begin
        {hi, lo} <= prod;
      end
    end
  end

  // Stalled edges push a bubble; data fields keep their value.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      ex_mem_q <= '0;
    end else if (i_step) begin
      if (o_stall) begin
        ex_mem_q.branch_taken <= 1'b0;
        ex_mem_q.mem_read     <= 1'b0;
        ex_mem_q.mem_write    <= 1'b0;
        ex_mem_q.reg_write    <= 1'b0;
      end else begin
        ex_mem_q <= ex_mem_d;
      end
    end
  end

  assign ex.o_alu_result       = ex_mem_q.alu_result;
  assign ex.o_data_b           = ex_mem_q.data_b;
  assign ex.o_branch_target    = ex_mem_q.branch_target;
  assign ex.o_branch_taken     = ex_mem_q.branch_taken;
  assign ex.o_mem_read         = ex_mem_q.mem_read;
  assign ex.o_mem_write        = ex_mem_q.mem_write;
  assign ex.o_reg_write        = ex_mem_q.reg_write;
  assign ex.o_word_size        = ex_mem_q.word_size;
  assign ex.o_reg_dir_to_write = ex_mem_q.reg_dir;
endmodule
